buff_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream SimpleBuff input channel between `NUM_REQ` token-stream requesters. It grants one requester at a time and holds the grant for a whole message, where a message ends at a valid gap. It forwards that requester's FTk stream unchanged. Back-pressure (Nack) is routed to the granted requester only; every other requester is held off with Nack. The block sits between the producer ports of a compute cluster and the shared buffer/link in front of it.

---
 rtl/buff_rr_arbiter_pkg.sv | 26 ++
 rtl/buff_rr_arbiter_pick.sv | 28 ++
 rtl/buff_rr_arbiter.sv | 99 +++++++++
 tb/tb_buff_rr_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/buff_rr_arbiter_pkg.sv
// pkg_en: token types, arbiter FSM encoding and pointer-width helper
//   FTk_t         : forward token (v = valid/request, d = payload)
//   BTk_t         : back token (n = Nack, t/v/c = side-band flags)
//   arb_fsm_t     : IDLE=0, GRANT=1, STALL=2
//   WIDTH_ARB_PTR : width of the round-robin pointer for a requester count
package pkg_en;
  localparam int WIDTH_DATA = 32;
  typedef struct packed {
    logic v;
    logic [WIDTH_DATA-1:0] d;
  } FTk_t;
  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_t;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    STALL = 2'd2
  } arb_fsm_t;
  function automatic int WIDTH_ARB_PTR(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/buff_rr_arbiter_pick.sv
// arb_rr_pick: combinational rotate-priority encoder
//   req    in  [N]  : request vector
//   ptr    in  [W]  : highest-priority index for this pick
//   onehot out [N]  : winner one-hot (zero when no request)
//   idx    out [W]  : winner index
//   any    out      : at least one request
module arb_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [N-1:0] rot;
  int off;
  // rotate so ptr lands at bit 0, then the lowest set bit is the winner's offset
  always_comb begin
    rot = N'({req, req} >> ptr);
    off = 0;
    for (int k = N - 1; k >= 0; k--) if (rot[k]) off = k;
    idx = W'((int'(ptr) + off) % N);
    any = |req;
    onehot = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/buff_rr_arbiter.sv
// buff_rr_arbiter: round-robin, message-granular arbiter onto one SimpleBuff channel
//   clock, reset     : clock, asynchronous active-high reset
//   I_FTk [NUM_REQ]  : requester forward tokens (.v is the request)
//   O_BTk [NUM_REQ]  : back tokens to requesters (Nack unless granted)
//   O_FTk            : forwarded token of the granted requester
//   I_BTk            : downstream back token (.n is Nack)
//   O_Grant          : one-hot grant, zero when idle
//   O_Busy           : a grant is active
// Optional: define BUFF_ARB_MAX_BURST_EN to cap each grant at MAX_BURST accepted tokens.
import pkg_en::*;
module buff_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  FTk_t               I_FTk [NUM_REQ],
  output BTk_t               O_BTk [NUM_REQ],
  output FTk_t               O_FTk,
  input  BTk_t               I_BTk,
  output logic [NUM_REQ-1:0] O_Grant,
  output logic               O_Busy
);
  localparam int PW = WIDTH_ARB_PTR(NUM_REQ);
  if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_BURST < 1) begin : g_bad_cfg
    $error("buff_rr_arbiter: NUM_REQ must be 2..16 and MAX_BURST >= 1");
  end
  arb_fsm_t fsm, fsm_n;
  logic [NUM_REQ-1:0] grant, grant_n, req, pick;
  logic [PW-1:0] ptr, ptr_n, pick_idx;
  logic pick_any, rel;
  FTk_t fwd;
  arb_rr_pick #(.N(NUM_REQ), .W(PW)) u_pick (
    .req(req), .ptr(ptr), .onehot(pick), .idx(pick_idx), .any(pick_any)
  );
  // grant is zero whenever idle, so masking by it gives the idle/reset outputs for free
  always_comb begin
    fwd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i] = I_FTk[i].v;
      if (grant[i]) fwd = I_FTk[i];
      O_BTk[i] = grant[i] ? I_BTk : BTk_t'{n: 1'b1, default: 1'b0};
    end
  end
  assign O_FTk = fwd;
  assign O_Grant = grant;
  assign O_Busy = fsm != IDLE;
`ifdef BUFF_ARB_MAX_BURST_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] cnt, cnt_n;
  assign rel = !fwd.v || cnt == CW'(MAX_BURST - 1);
`else
  assign rel = !fwd.v;
`endif
  always_comb begin
    fsm_n = fsm;
    grant_n = grant;
    ptr_n = ptr;
`ifdef BUFF_ARB_MAX_BURST_EN
    cnt_n = cnt;
`endif
    case (fsm)
      IDLE: if (pick_any) begin
        fsm_n = GRANT;
        grant_n = pick;
        ptr_n = (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end
      GRANT: begin
        // Nack takes priority over a simultaneous valid gap
        fsm_n = I_BTk.n ? STALL : rel ? IDLE : GRANT;
        grant_n = (!I_BTk.n && rel) ? '0 : grant;
`ifdef BUFF_ARB_MAX_BURST_EN
        cnt_n = I_BTk.n ? cnt : rel ? '0 : cnt + 1'b1;
`endif
      end
      STALL: fsm_n = I_BTk.n ? STALL : GRANT;
      default: begin
        fsm_n = IDLE;
        grant_n = '0;
      end
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      fsm <= IDLE;
      grant <= '0;
      ptr <= '0;
`ifdef BUFF_ARB_MAX_BURST_EN
      cnt <= '0;
`endif
    end else begin
      fsm <= fsm_n;
      grant <= grant_n;
      ptr <= ptr_n;
`ifdef BUFF_ARB_MAX_BURST_EN
      cnt <= cnt_n;
`endif
    end
endmodule

// File: tb/tb_buff_rr_arbiter.sv
// tb_buff_rr_arbiter: directed and randomized checks of buff_rr_arbiter against a behavioural model
import pkg_en::*;
module tb_buff_rr_arbiter;
  localparam int N = 4;
  localparam int MB = 4;
  logic clk = 0, rst = 0;
  FTk_t ftk_in [N];
  BTk_t btk_out [N];
  FTk_t ftk_out;
  BTk_t btk_in;
  logic [N-1:0] grant;
  logic busy;
  int nvec = 0, nerr = 0;
  bit acc [N];
  always #5 clk = ~clk;
  buff_rr_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clock(clk), .reset(rst), .I_FTk(ftk_in), .O_BTk(btk_out), .O_FTk(ftk_out),
    .I_BTk(btk_in), .O_Grant(grant), .O_Busy(busy)
  );
  // model: owner is the granted requester (-1 = nobody), nxt the requester with top priority
  int owner = -1, nxt = 0, burst = 0;
  bit stalled = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      owner = -1;
      nxt = 0;
      burst = 0;
      stalled = 0;
    end else if (owner < 0) begin
      for (int k = 0; k < N; k++)
        if (owner < 0 && ftk_in[(nxt + k) % N].v) owner = (nxt + k) % N;
      if (owner >= 0) nxt = (owner + 1) % N;
    end else if (stalled) stalled = btk_in.n;
    else if (btk_in.n) stalled = 1;
    else if (!ftk_in[owner].v) begin
      owner = -1;
      burst = 0;
    end else begin
      burst++;
`ifdef BUFF_ARB_MAX_BURST_EN
      if (burst == MB) begin
        owner = -1;
        burst = 0;
      end
`endif
    end
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    FTk_t ef;
    logic [N-1:0] eg;
    ef = (owner >= 0) ? ftk_in[owner] : '0;
    eg = (owner >= 0) ? N'(1) << owner : '0;
    check("grant", grant, eg);
    check("busy", busy, owner >= 0);
    check("ftk", ftk_out, ef);
    for (int i = 0; i < N; i++) check($sformatf("btk%0d", i), btk_out[i], (i == owner) ? btk_in : 4'b1000);
  end
  // mode 0: manual, 1: one-token messages, 2: random, 3: continuous streaming
  task automatic step(input int mode);
    for (int i = 0; i < N; i++) acc[i] = (owner == i) && ftk_in[i].v && !btk_in.n;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (mode == 1) begin
        if (acc[i]) ftk_in[i].v = 0;
        else if (!ftk_in[i].v) begin
          ftk_in[i].v = 1;
          ftk_in[i].d++;
        end
      end else if (mode == 2) begin
        if (acc[i] || !ftk_in[i].v) begin
          ftk_in[i].v = acc[i] ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 2) == 0);
          ftk_in[i].d = $urandom;
        end
      end else if (mode == 3 && acc[i]) ftk_in[i].d++;
    end
    if (mode == 2) btk_in = BTk_t'({$urandom_range(0, 3) == 0, 3'($urandom)});
  endtask
  task automatic do_reset();
    rst = 1;
    for (int i = 0; i < N; i++) ftk_in[i] = '0;
    btk_in = '0;
    @(posedge clk);
    #1;
    rst = 0;
  endtask
  initial begin
    for (int i = 0; i < N; i++) ftk_in[i] = '0;
    btk_in = '0;
    #1 rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_ftk", ftk_out, 0);
    check("rst_btk1_n", btk_out[1].n, 1);
    @(posedge clk);
    #1 rst = 0;
    ftk_in[2] = '{v: 1'b1, d: 32'hA};
    step(0);
    @(negedge clk);
    check("t1_grant", grant, 4'b0100);
    check("t1_dA", ftk_out.d, 32'hA);
    step(0);
    ftk_in[2].d = 32'hB;
    @(negedge clk);
    check("t1_dB", ftk_out.d, 32'hB);
    step(0);
    ftk_in[2].d = 32'hC;
    @(negedge clk);
    check("t1_dC", ftk_out.d, 32'hC);
    check("t1_btk0_n", btk_out[0].n, 1);
    check("t1_btk3_n", btk_out[3].n, 1);
    step(0);
    ftk_in[2].v = 0;
    @(negedge clk);
    check("t1_gap_grant", grant, 4'b0100);
    step(0);
    @(negedge clk);
    check("t1_idle", busy, 0);
    ftk_in[1] = '{v: 1'b1, d: 32'h11};
    step(0);
    btk_in.n = 1;
    @(negedge clk);
    check("st_nack_mirror", btk_out[1].n, 1);
    step(0);
    ftk_in[1].v = 0;
    step(0);
    @(negedge clk);
    check("st_hold_busy", busy, 1);
    check("st_hold_grant", grant, 4'b0010);
    step(0);
    step(0);
    btk_in.n = 0;
    @(negedge clk);
    check("st_nack_drop", btk_out[1].n, 0);
    step(0);
    @(negedge clk);
    check("st_resume", busy, 1);
    step(0);
    @(negedge clk);
    check("st_release", busy, 0);
    ftk_in[3] = '{v: 1'b1, d: 32'h33};
    step(0);
    @(negedge clk);
    check("ar_grant", grant, 4'b1000);
    #2 rst = 1;
    #1;
    check("ar_grant0", grant, 0);
    check("ar_v0", ftk_out.v, 0);
    check("ar_busy0", busy, 0);
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < N; i++) ftk_in[i].v = 1;
    for (int c = 1; c <= 13; c++) begin
      step(1);
      @(negedge clk);
      if (c % 3 == 1) check($sformatf("rr_c%0d", c), grant, N'(1) << ((c / 3) % N));
    end
    do_reset();
    ftk_in[0].v = 1;
    ftk_in[1].v = 1;
    for (int c = 1; c <= 10; c++) begin
      step(3);
      @(negedge clk);
`ifdef BUFF_ARB_MAX_BURST_EN
      if (c <= 9) check($sformatf("burst_c%0d", c), grant, (c <= 4) ? 4'b0001 : (c == 5) ? 4'b0000 : 4'b0010);
`else
      check($sformatf("stream_c%0d", c), grant, 4'b0001);
`endif
    end
    do_reset();
    repeat (4000) step(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
